// File: rtl/cbus_mem_responder_pkg.sv
// Shared CBUS types: request/response structs, burst and length encodings, bus widths.
// No logic; latency n/a.
// Flow control is ready-only: the responder never stalls a beat once it is in its burst phase.
package cbus_mem_responder_pkg;

  localparam int CBUS_ADDR_W = 64;
  localparam int CBUS_DATA_W = 64;
  localparam int CBUS_STRB_W = CBUS_DATA_W / 8;
  localparam int CBUS_LEN_W  = 4;
  localparam int CBUS_SIZE_W = 3;

  // The remaining codes are reserved and behave like FIXED (the index is held).
  typedef enum logic [1:0] {
    CBUS_BURST_FIXED = 2'd0,
    CBUS_BURST_INCR  = 2'd1,
    CBUS_BURST_RSV2  = 2'd2,
    CBUS_BURST_RSV3  = 2'd3
  } cbus_burst_e;

  // len holds the number of beats minus one.
  typedef struct packed {
    logic                   valid;
    logic                   is_write;
    logic [CBUS_SIZE_W-1:0] size;
    logic [CBUS_ADDR_W-1:0] addr;
    logic [CBUS_STRB_W-1:0] strobe;
    logic [CBUS_DATA_W-1:0] data;
    logic [CBUS_LEN_W-1:0]  len;
    cbus_burst_e            burst;
  } cbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } resp_state_e;

endpackage

// File: rtl/cbus_mem_bank.sv
// Word-addressed backing store, MEM_WORDS x 64 bits, with per-byte write enables.
// Read is combinational from rd_idx; a write lands at the rising edge while wr_en is high.
// No backpressure: every enabled write is accepted. Contents are never reset.
module cbus_mem_bank
  import cbus_mem_responder_pkg::*;
#(
  parameter  int MEM_WORDS = 4096,
  localparam int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic                   clk,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [CBUS_DATA_W-1:0] rd_dat,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [CBUS_STRB_W-1:0] wr_strb,
  input  logic [CBUS_DATA_W-1:0] wr_dat
);

  logic [CBUS_DATA_W-1:0] mem [MEM_WORDS];

  assign rd_dat = mem[rd_idx];

  // Byte-lane write: lanes with a clear strobe bit keep their old contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < CBUS_STRB_W; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/cbus_mem_responder.sv
// CBUS target backed by a cbus_mem_bank: single-beat or burst reads and writes, FIXED/INCR addressing.
// The first beat comes LATENCY idle cycles after acceptance, or the cycle after acceptance when LATENCY=0. Then one beat per cycle.
// The initiator cannot stall a burst. Dropping valid aborts the transaction at the next edge, and that cycle performs no write.
module cbus_mem_responder
  import cbus_mem_responder_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  // Last value of the latency counter before moving to BURST; unused when LATENCY=0.
  localparam logic [3:0] LAT_LAST = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  resp_state_e           state_q, state_d;
  logic [3:0]            lat_q, lat_d;
  logic [CBUS_LEN_W-1:0] beat_q, beat_d;
  logic [CBUS_LEN_W-1:0] len_q, len_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  is_write_q, is_write_d;
  cbus_burst_e           burst_q, burst_d;

  logic                   beat_vld;
  logic                   beat_last;
  logic                   wr_en;
  logic [CBUS_DATA_W-1:0] rd_dat;

  // The remaining request bits do not affect behaviour: size is ignored, and the upper and byte-offset address bits are ignored.
  logic unused_req_bits;
  assign unused_req_bits = ^{creq.size, creq.addr[CBUS_ADDR_W-1:3+IDX_W], creq.addr[2:0]};

  // State and transaction registers. Reset returns to IDLE with all counters and the index cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lat_q      <= '0;
      beat_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      is_write_q <= 1'b0;
      burst_q    <= CBUS_BURST_FIXED;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      beat_q     <= beat_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      is_write_q <= is_write_d;
      burst_q    <= burst_d;
    end
  end

  // Next-state logic: latch the request in IDLE, count the latency in WAIT, and step the beat counter and index in BURST.
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    beat_d     = beat_q;
    len_d      = len_q;
    idx_d      = idx_q;
    is_write_d = is_write_q;
    burst_d    = burst_q;
    beat_vld   = 1'b0;
    beat_last  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (creq.valid) begin
          is_write_d = creq.is_write;
          len_d      = creq.len;
          burst_d    = creq.burst;
          idx_d      = creq.addr[3 +: IDX_W];
          lat_d      = '0;
          beat_d     = '0;
          state_d    = (LATENCY == 0) ? ST_BURST : ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (!creq.valid) begin
          state_d = ST_IDLE;
        end else if (lat_q == LAT_LAST) begin
          lat_d   = '0;
          state_d = ST_BURST;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end

      ST_BURST: begin
        if (!creq.valid) begin
          state_d = ST_IDLE;
        end else begin
          beat_vld  = 1'b1;
          beat_last = (beat_q == len_q);
          beat_d    = beat_q + 4'd1;
          if (burst_q == CBUS_BURST_INCR) begin
            idx_d = idx_q + IDX_W'(1);
          end
          if (beat_last) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset also gates the write enable, so a write cannot slip through in the cycle reset is asserted.
  assign wr_en = beat_vld && is_write_q && !reset;

  // Response: quiet unless a beat is in progress; read data appears only on read beats.
  always_comb begin
    cresp = '0;
    if (beat_vld && !reset) begin
      cresp.ready = 1'b1;
      cresp.last  = beat_last;
      if (!is_write_q) begin
        cresp.data = rd_dat;
      end
    end
  end

  cbus_mem_bank #(
    .MEM_WORDS(MEM_WORDS)
  ) u_bank (
    .clk    (clk),
    .rd_idx (idx_q),
    .rd_dat (rd_dat),
    .wr_en  (wr_en),
    .wr_idx (idx_q),
    .wr_strb(creq.strobe),
    .wr_dat (creq.data)
  );

endmodule

// File: tb/tb_cbus_mem_responder.sv
`timescale 1ns/1ps
module tb_cbus_mem_responder;
  import cbus_mem_responder_pkg::*;

  localparam int MW  = 4096;
  localparam int LAT = 2;
  localparam int MW0 = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  cbus_req_t  creq, creq0;
  cbus_resp_t cresp, cresp0;

  cbus_mem_responder #(.MEM_WORDS(MW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .creq(creq), .cresp(cresp));

  cbus_mem_responder #(.MEM_WORDS(MW0), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .creq(creq0), .cresp(cresp0));

  int checks = 0;
  int failures = 0;

  // Reference memory: only words the bench has fully defined are present.
  logic [63:0] mem_m [int];
  logic [63:0] wq [$];

  bit          cmp_en = 1'b0;
  logic        exp_ready, exp_last;
  logic [63:0] exp_data;
  bit          exp_dchk;
  bit          cur_wr;
  int          beats_seen;
  logic [63:0] last_rd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare DUT outputs with the expectations published by the driver, once per cycle on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready", {63'd0, cresp.ready}, {63'd0, exp_ready});
      chk("last",  {63'd0, cresp.last},  {63'd0, exp_last});
      if (exp_dchk) chk("data", cresp.data, exp_data);
      if (cresp.ready === 1'b1) begin
        beats_seen++;
        if (!cur_wr) last_rd = cresp.data;
      end
    end
  end

  // Drive one transaction and publish the expected response for each cycle.
  // If stop_beat >= 0, the transaction is cut at that beat: by reset when stop_rst is set, otherwise by dropping valid.
  task automatic txn(input bit wr, input logic [63:0] addr, input logic [3:0] len,
                     input cbus_burst_e burst, input logic [7:0] strb,
                     input int stop_beat, input bit stop_rst);
    int          base;
    int          idx;
    logic [63:0] m;
    logic [63:0] d;
    base = int'((addr / 64'd8) % 64'(MW));
    cur_wr = wr;
    beats_seen = 0;
    creq = '0;
    creq.valid = 1'b1; creq.is_write = wr; creq.addr = addr; creq.len = len;
    creq.burst = burst; creq.strobe = strb; creq.size = 3'd3;
    exp_ready = 1'b0; exp_last = 1'b0; exp_data = 64'd0; exp_dchk = 1'b1;
    cmp_en = 1'b1;
    // Acceptance cycle plus LAT idle cycles. After acceptance the latched fields are scrambled; the DUT must ignore them.
    for (int w = 0; w <= LAT; w++) begin
      @(posedge clk); #1;
      creq.addr = ~addr; creq.len = ~len; creq.is_write = ~wr;
      creq.burst = (burst == CBUS_BURST_INCR) ? CBUS_BURST_FIXED : CBUS_BURST_INCR;
    end
    for (int k = 0; k <= int'(len); k++) begin
      idx = (burst == CBUS_BURST_INCR) ? (base + k) % MW : base;
      if (k == stop_beat) begin
        exp_ready = 1'b0; exp_last = 1'b0; exp_data = 64'd0; exp_dchk = 1'b1;
        if (wr) creq.data = wq[k];
        if (stop_rst) begin
          #2 reset = 1'b1;
        end else begin
          creq.valid = 1'b0;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        break;
      end
      exp_ready = 1'b1;
      exp_last  = (k == int'(len));
      if (wr) begin
        d = wq[k];
        creq.data = d;
        exp_dchk = 1'b0;
        if (mem_m.exists(idx) || strb == 8'hFF) begin
          m = 64'd0;
          if (mem_m.exists(idx)) m = mem_m[idx];
          for (int b = 0; b < 8; b++) if (strb[b]) m[8*b +: 8] = d[8*b +: 8];
          mem_m[idx] = m;
        end
      end else begin
        exp_dchk = mem_m.exists(idx);
        exp_data = 64'd0;
        if (exp_dchk) exp_data = mem_m[idx];
      end
      @(posedge clk); #1;
    end
    creq.valid = 1'b0;
    exp_ready = 1'b0; exp_last = 1'b0; exp_data = 64'd0; exp_dchk = 1'b1;
    @(posedge clk); #1;
  endtask

  // Single cycle on the zero-latency instance, with expectations written out by hand.
  task automatic cyc0(input string nm, input bit er, input bit el, input bit dchk, input logic [63:0] ed);
    @(negedge clk);
    chk({nm, "_ready"}, {63'd0, cresp0.ready}, {63'd0, er});
    chk({nm, "_last"},  {63'd0, cresp0.last},  {63'd0, el});
    if (dchk) chk({nm, "_data"}, cresp0.data, ed);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    creq  = '0;
    creq0 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {63'd0, cresp.ready}, 64'd0);
    chk("rst_last",  {63'd0, cresp.last},  64'd0);
    chk("rst_data",  cresp.data, 64'd0);
    chk("rst_ready0", {63'd0, cresp0.ready}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single read after preload
    wq = '{64'hDEADBEEF_CAFEF00D};
    txn(1'b1, 64'h80, 4'd0, CBUS_BURST_INCR, 8'hFF, -1, 1'b0);
    txn(1'b0, 64'h80, 4'd0, CBUS_BURST_INCR, 8'h00, -1, 1'b0);
    chk("single_rd_beats", 64'(beats_seen), 64'd1);
    chk("single_rd_data", last_rd, 64'hDEADBEEF_CAFEF00D);

    // Masked write
    wq = '{64'h1111_1111_1111_1111};
    txn(1'b1, 64'h100, 4'd0, CBUS_BURST_FIXED, 8'hFF, -1, 1'b0);
    wq = '{64'hAAAAAAAA_BBBBBBBB};
    txn(1'b1, 64'h100, 4'd0, CBUS_BURST_FIXED, 8'h0F, -1, 1'b0);
    txn(1'b0, 64'h100, 4'd0, CBUS_BURST_FIXED, 8'h00, -1, 1'b0);
    chk("masked_wr", last_rd, 64'h11111111_BBBBBBBB);

    // INCR burst that wraps past the top of memory
    wq = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
    txn(1'b1, 64'(MW - 2) * 64'd8, 4'd3, CBUS_BURST_INCR, 8'hFF, -1, 1'b0);
    txn(1'b0, 64'(MW - 2) * 64'd8, 4'd3, CBUS_BURST_INCR, 8'h00, -1, 1'b0);
    chk("wrap_rd_beats", 64'(beats_seen), 64'd4);
    chk("wrap_rd_word1", last_rd, 64'hA3);
    txn(1'b0, 64'h0, 4'd0, CBUS_BURST_INCR, 8'h00, -1, 1'b0);
    chk("wrap_rd_word0", last_rd, 64'hA2);

    // FIXED write burst at word 5; word 6 must keep its value. Upper address bits are ignored.
    wq = '{64'hC6};
    txn(1'b1, 64'h30, 4'd0, CBUS_BURST_INCR, 8'hFF, -1, 1'b0);
    wq = '{64'h5A, 64'h5B};
    txn(1'b1, 64'hF000_0000_0000_0028, 4'd1, CBUS_BURST_FIXED, 8'hFF, -1, 1'b0);
    txn(1'b0, 64'h28, 4'd0, CBUS_BURST_FIXED, 8'h00, -1, 1'b0);
    chk("fixed_wr_w5", last_rd, 64'h5B);
    txn(1'b0, 64'h30, 4'd0, CBUS_BURST_FIXED, 8'h00, -1, 1'b0);
    chk("fixed_wr_w6", last_rd, 64'hC6);

    // Reset on beat 2 of a len-3 write; beats 2-4 must not be written
    wq = '{64'hB0, 64'hB1, 64'hB2, 64'hB3};
    txn(1'b1, 64'h200, 4'd3, CBUS_BURST_INCR, 8'hFF, -1, 1'b0);
    wq = '{64'hE0, 64'hE1, 64'hE2, 64'hE3};
    txn(1'b1, 64'h200, 4'd3, CBUS_BURST_INCR, 8'hFF, 1, 1'b1);
    txn(1'b0, 64'h200, 4'd3, CBUS_BURST_INCR, 8'h00, -1, 1'b0);
    chk("rst_mid_beats", 64'(beats_seen), 64'd4);
    chk("rst_mid_w43", last_rd, 64'hB3);

    // valid dropped mid-burst: read aborts; write is suppressed on the aborted beat
    txn(1'b0, 64'h200, 4'd3, CBUS_BURST_INCR, 8'h00, 2, 1'b0);
    chk("abort_rd_beats", 64'(beats_seen), 64'd2);
    wq = '{64'hF0, 64'hF1};
    txn(1'b1, 64'h80, 4'd1, CBUS_BURST_FIXED, 8'hFF, 1, 1'b0);
    txn(1'b0, 64'h80, 4'd0, CBUS_BURST_FIXED, 8'h00, -1, 1'b0);
    chk("abort_wr_data", last_rd, 64'hF0);
    cmp_en = 1'b0;

    // LATENCY=0: back-to-back transactions with valid held through the IDLE cycle
    creq0 = '0;
    creq0.valid = 1'b1; creq0.is_write = 1'b1; creq0.addr = 64'h18; creq0.strobe = 8'hFF;
    creq0.data = 64'h0123_4567_89AB_CDEF; creq0.burst = CBUS_BURST_INCR;
    cyc0("l0_wr1_acc", 1'b0, 1'b0, 1'b1, 64'd0);
    cyc0("l0_wr1_beat", 1'b1, 1'b1, 1'b0, 64'd0);
    creq0.addr = 64'h20; creq0.data = 64'hFEDC_BA98_7654_3210;
    cyc0("l0_wr2_acc", 1'b0, 1'b0, 1'b1, 64'd0);
    cyc0("l0_wr2_beat", 1'b1, 1'b1, 1'b0, 64'd0);
    creq0.valid = 1'b0;
    cyc0("l0_idle", 1'b0, 1'b0, 1'b1, 64'd0);
    creq0.valid = 1'b1; creq0.is_write = 1'b0; creq0.addr = 64'h18;
    cyc0("l0_rd1_acc", 1'b0, 1'b0, 1'b1, 64'd0);
    cyc0("l0_rd1_beat", 1'b1, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF);
    creq0.addr = 64'h20;
    cyc0("l0_rd2_acc", 1'b0, 1'b0, 1'b1, 64'd0);
    cyc0("l0_rd2_beat", 1'b1, 1'b1, 1'b1, 64'hFEDC_BA98_7654_3210);
    creq0.valid = 1'b0;
    cyc0("l0_end", 1'b0, 1'b0, 1'b1, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cbus_mem_responder.md
CBUS_MEM_RESPONDER -- requirements
Module: cbus_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, number of 64-bit words in the backing array (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, idle cycles between request acceptance and the first data beat (range 0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port creq  input  cbus_req_t  initiator request: valid, is_write, size, addr(64), strobe(8), data(64), len(4, beats-1), burst.
REQ-006 SHALL have port cresp  output  cbus_resp_t  response: ready(1), last(1), data(64).

Function
REQ-007 SHALL implement FSM states IDLE, WAIT, BURST.
REQ-008 In IDLE with creq.valid=1, SHALL latch is_write, len, burst and word index addr[3+log2(MEM_WORDS)-1:3], then enter WAIT; with LATENCY=0, SHALL enter BURST directly.
REQ-009 In WAIT, SHALL count LATENCY cycles, then enter BURST; ready=0 throughout.
REQ-010 In BURST, SHALL drive ready=1 every cycle; each cycle is one beat.
REQ-011 Beat counter SHALL start at 0; last=1 when ready=1 and counter equals latched len.
REQ-012 On the last beat, SHALL return to IDLE at the following edge; the initiator deasserts valid the cycle after observing last, so no re-acceptance occurs.
REQ-013 Read beats SHALL drive cresp.data = array[index] combinationally from the current index; data SHALL be 0 when ready=0.
REQ-014 Write beats SHALL update the bytes of array[index] for which creq.strobe[i]=1 using creq.data at the beat's edge; other bytes SHALL be unchanged.
REQ-015 For burst INCR, index SHALL increment by 1 per beat, wrapping modulo MEM_WORDS; for FIXED, index SHALL stay constant.
REQ-016 size SHALL be ignored; reads always return the full word; writes are governed only by strobe.
REQ-017 If creq.valid drops while in WAIT or BURST, SHALL abort to IDLE at the next edge with no write that cycle; ready and last SHALL be 0 in the cycle valid is low.
REQ-018 Request fields other than data and strobe SHALL be sampled only in IDLE; later changes are ignored.

Reset
REQ-019 Reset SHALL force IDLE, clear the beat counter, latency counter and index, and drive ready=0, last=0, data=0 immediately.
REQ-020 Reset asserted mid-burst SHALL suppress the write of that cycle and terminate the transaction.
REQ-021 Array contents SHALL NOT be reset.

Structure
REQ-022 cbus_req_t, cbus_resp_t, the burst and len encodings, and the word/strobe widths SHALL come from the shared common package; no local redefinition.
REQ-023 The backing array SHALL be a sub-module, cbus_mem_bank: MEM_WORDS x 64, asynchronous read, synchronous byte-enabled write.
REQ-024 FSM, counters and handshake logic SHALL reside in cbus_mem_responder.

Verification
REQ-025 Single read: preload word 0x10 = 0xDEADBEEF_CAFEF00D, read addr 0x80 with len 0 -> after 2 idle cycles, one beat with ready=1, last=1 and data matching the preload.
REQ-026 Masked write: word 0x20 = 0x11..11, write addr 0x100, strobe 0x0F, data 0xAAAAAAAA_BBBBBBBB -> readback 0x11111111_BBBBBBBB.
REQ-027 INCR burst read with len 3 from word MEM_WORDS-2 -> four beats from words MEM_WORDS-2, MEM_WORDS-1, 0, 1; last only on beat 4.
REQ-028 FIXED burst write with len 1 at word 5, data A then B, full strobe -> word 5 = B, word 6 unchanged.
REQ-029 Reset on beat 2 of a len-3 write burst -> ready=0 the same cycle; beats 2-4 not written; the next request is accepted normally.
REQ-030 LATENCY=0 back-to-back reads: valid reasserted the cycle after last -> second transaction accepted and its first beat on the next cycle.
